// File: rtl/irq_prio_ctrl_pkg.sv
// Shared types and cause codes for the interrupt priority front-end.
// Cause is {nmi, code}; fast channels map to code 16 + channel index.
package irq_prio_ctrl_pkg;

    localparam logic [4:0] IRQ_CODE_SW        = 5'd3;
    localparam logic [4:0] IRQ_CODE_TIMER     = 5'd7;
    localparam logic [4:0] IRQ_CODE_EXT       = 5'd11;
    localparam logic [4:0] IRQ_CODE_FAST_BASE = 5'd16;

    typedef struct packed {
        logic       nmi;
        logic [4:0] code;
    } irq_cause_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2
    } irq_ctrl_fsm_e;

    function automatic irq_cause_t fast_cause(input logic [3:0] id);
        irq_cause_t c;
        c.nmi  = 1'b0;
        c.code = IRQ_CODE_FAST_BASE + {1'b0, id};
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Picks the eligible fast channel with the highest priority value;
// on equal priority the lowest index wins.
module irq_prio_arb #(
    parameter int NUM_FAST = 15,
    parameter int PRIO_W   = 3
) (
    input  logic [NUM_FAST-1:0]        req,
    input  logic [NUM_FAST*PRIO_W-1:0] prio,
    output logic                       valid,
    output logic [3:0]                 id
);

    logic [PRIO_W-1:0] best_prio;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        valid     = 1'b0;
        id        = '0;
        best_prio = '0;
        // Strict '>' keeps the earlier (lower) index on a tie.
        for (int i = 0; i < NUM_FAST; i++) begin
            if (req[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                valid     = 1'b1;
                id        = 4'(i);
                best_prio = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt front-end: latches and masks NMI, fast and standard sources, arbitrates them
// and presents one registered cause to the controller on a req/ack handshake.
module irq_prio_ctrl
    import irq_prio_ctrl_pkg::*;
#(
    parameter int NUM_FAST = 15,
    parameter int PRIO_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       irq_software_i,
    input  logic                       irq_timer_i,
    input  logic                       irq_external_i,
    input  logic [NUM_FAST-1:0]        irq_fast_i,
    input  logic                       irq_nm_ext_i,
    input  logic [2:0]                 mie_std_i,
    input  logic [NUM_FAST-1:0]        mie_fast_i,
    input  logic [NUM_FAST-1:0]        edge_mode_i,
    input  logic [NUM_FAST*PRIO_W-1:0] fast_prio_i,
    input  logic                       csr_mstatus_mie_i,
    input  logic                       debug_mode_i,
    input  logic                       debug_single_step_i,
    input  logic                       nmi_mode_i,
    input  logic                       irq_ack_i,
    output logic                       irq_req_o,
    output irq_cause_t                 irq_cause_o,
    output logic                       irq_pending_o,
    output logic                       wake_o,
    output logic [NUM_FAST-1:0]        fast_pending_o
);

    logic [NUM_FAST-1:0] fast_line_q, fast_pend_q, fast_pend_d;
    logic [NUM_FAST-1:0] prio_nz, fast_clr, fast_en, fast_elig;
    logic [2:0]          std_pend_q, std_en, std_elig;   // {ext, timer, sw}
    logic                nmi_line_q, nmi_pend_q, nmi_pend_d, nmi_elig, global_ok;
    logic                fast_valid, arb_valid;
    logic [3:0]          fast_id;
    irq_cause_t          arb_cause, cause_q, cause_d;
    irq_ctrl_fsm_e       state_q, state_d;

    always_comb begin
        prio_nz  = '0;
        fast_clr = '0;
        for (int i = 0; i < NUM_FAST; i++) begin
            prio_nz[i]  = |fast_prio_i[i*PRIO_W +: PRIO_W];
            fast_clr[i] = (state_q == CLEAR) && !cause_q.nmi && cause_q.code[4]
                          && (cause_q.code[3:0] == 4'(i));
        end
    end

    // Edge channels hold until cleared; a new edge in the clear cycle wins over the clear.
    always_comb begin
        for (int i = 0; i < NUM_FAST; i++) begin
            fast_pend_d[i] = edge_mode_i[i]
                ? ((fast_pend_q[i] & ~fast_clr[i]) | (irq_fast_i[i] & ~fast_line_q[i]))
                : irq_fast_i[i];
        end
    end

    assign nmi_pend_d = (nmi_pend_q & ~((state_q == CLEAR) & cause_q.nmi))
                      | (irq_nm_ext_i & ~nmi_line_q);

    assign global_ok = csr_mstatus_mie_i & ~debug_mode_i & ~debug_single_step_i & ~nmi_mode_i;
    assign nmi_elig  = nmi_pend_q & ~nmi_mode_i & ~debug_mode_i & ~debug_single_step_i;
    assign fast_en   = fast_pend_q & mie_fast_i & prio_nz;
    assign fast_elig = fast_en & {NUM_FAST{global_ok}};
    assign std_en    = std_pend_q & mie_std_i;
    assign std_elig  = std_en & {3{global_ok}};

    irq_prio_arb #(
        .NUM_FAST (NUM_FAST),
        .PRIO_W   (PRIO_W)
    ) u_arb (
        .req   (fast_elig),
        .prio  (fast_prio_i),
        .valid (fast_valid),
        .id    (fast_id)
    );

    always_comb begin
        arb_valid = 1'b1;
        arb_cause = '0;
        if (nmi_elig) begin
            arb_cause.nmi = 1'b1;
        end else if (fast_valid) begin
            arb_cause = fast_cause(fast_id);
        end else if (std_elig[2]) begin
            arb_cause.code = IRQ_CODE_EXT;
        end else if (std_elig[0]) begin
            arb_cause.code = IRQ_CODE_SW;
        end else if (std_elig[1]) begin
            arb_cause.code = IRQ_CODE_TIMER;
        end else begin
            arb_valid = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = REQ;
                    cause_d = arb_cause;
                end
            end
            REQ: begin
                // Only a global-enable or debug change withdraws; a dropped source line does not.
                if (irq_ack_i) begin
                    state_d = CLEAR;
                end else if (!cause_q.nmi &&
                             (!csr_mstatus_mie_i || debug_mode_i || debug_single_step_i)) begin
                    state_d = IDLE;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            fast_line_q <= '0;
            fast_pend_q <= '0;
            std_pend_q  <= '0;
            nmi_line_q  <= 1'b0;
            nmi_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            fast_line_q <= irq_fast_i;
            fast_pend_q <= fast_pend_d;
            std_pend_q  <= {irq_external_i, irq_timer_i, irq_software_i};
            nmi_line_q  <= irq_nm_ext_i;
            nmi_pend_q  <= nmi_pend_d;
        end
    end

    assign irq_req_o      = (state_q == REQ);
    assign irq_cause_o    = cause_q;
    assign irq_pending_o  = (|fast_en) | (|std_en);
    assign wake_o         = irq_pending_o | nmi_pend_q;
    assign fast_pending_o = fast_pend_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: expected causes are queued when stimulus is
// driven and popped when the DUT raises a request.
module tb_irq_prio_ctrl;
    import irq_prio_ctrl_pkg::*;

    localparam int NUM_FAST = 15;
    localparam int PRIO_W   = 3;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       irq_software_i, irq_timer_i, irq_external_i;
    logic [NUM_FAST-1:0]        irq_fast_i;
    logic                       irq_nm_ext_i;
    logic [2:0]                 mie_std_i;
    logic [NUM_FAST-1:0]        mie_fast_i, edge_mode_i;
    logic [NUM_FAST*PRIO_W-1:0] fast_prio_i;
    logic                       csr_mstatus_mie_i, debug_mode_i, debug_single_step_i;
    logic                       nmi_mode_i, irq_ack_i;
    logic                       irq_req_o, irq_pending_o, wake_o;
    irq_cause_t                 irq_cause_o;
    logic [NUM_FAST-1:0]        fast_pending_o;

    int         vectors     = 0;
    int         miscompares = 0;
    irq_cause_t exp_q[$];

    irq_prio_ctrl #(.NUM_FAST(NUM_FAST), .PRIO_W(PRIO_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .irq_software_i      (irq_software_i),
        .irq_timer_i         (irq_timer_i),
        .irq_external_i      (irq_external_i),
        .irq_fast_i          (irq_fast_i),
        .irq_nm_ext_i        (irq_nm_ext_i),
        .mie_std_i           (mie_std_i),
        .mie_fast_i          (mie_fast_i),
        .edge_mode_i         (edge_mode_i),
        .fast_prio_i         (fast_prio_i),
        .csr_mstatus_mie_i   (csr_mstatus_mie_i),
        .debug_mode_i        (debug_mode_i),
        .debug_single_step_i (debug_single_step_i),
        .nmi_mode_i          (nmi_mode_i),
        .irq_ack_i           (irq_ack_i),
        .irq_req_o           (irq_req_o),
        .irq_cause_o         (irq_cause_o),
        .irq_pending_o       (irq_pending_o),
        .wake_o              (wake_o),
        .fast_pending_o      (fast_pending_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cause(input logic nmi, input logic [4:0] code);
        exp_q.push_back({nmi, code});
    endtask

    // Waits (bounded) for a request, then compares its cause against the oldest expectation.
    task automatic take_req(input string tag);
        int         n = 0;
        irq_cause_t e;
        while (!irq_req_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(irq_req_o), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
        check({tag, "_cause"}, 32'(irq_cause_o), 32'(e));
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic set_prio(input int ch, input logic [PRIO_W-1:0] p);
        fast_prio_i[ch*PRIO_W +: PRIO_W] = p;
    endtask

    initial begin
        rst_n = 1'b0;
        irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0; irq_nm_ext_i = 0;
        irq_fast_i = '0; mie_std_i = '0; mie_fast_i = '0; edge_mode_i = '0; fast_prio_i = '0;
        csr_mstatus_mie_i = 1; debug_mode_i = 0; debug_single_step_i = 0;
        nmi_mode_i = 0; irq_ack_i = 0;
        #12;
        check("rst_req",   32'(irq_req_o), 0);
        check("rst_cause", 32'(irq_cause_o), 0);
        check("rst_wake",  32'(wake_o), 0);
        check("rst_fpend", 32'(fast_pending_o), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: level fast[2], exact latency, re-request after ack while line stays high
        set_prio(2, 3'd3);
        mie_fast_i[2] = 1'b1;
        expect_cause(1'b0, 5'd18);
        irq_fast_i[2] = 1'b1;
        tick();
        check("t1_lat_n1",  32'(irq_req_o), 0);
        check("t1_pend_n1", 32'(fast_pending_o[2]), 1);
        tick();
        check("t1_lat_n2", 32'(irq_req_o), 1);
        take_req("t1a");
        tick(); tick();
        check("t1_hold_req",   32'(irq_req_o), 1);
        check("t1_hold_cause", 32'(irq_cause_o), 32'({1'b0, 5'd18}));
        ack();
        check("t1_clear_low", 32'(irq_req_o), 0);
        tick();
        check("t1_idle_low", 32'(irq_req_o), 0);
        expect_cause(1'b0, 5'd18);
        tick();
        check("t1_rereq", 32'(irq_req_o), 1);
        take_req("t1b");
        irq_fast_i[2] = 1'b0;
        ack();
        tick(); tick();
        check("t1_done_req",  32'(irq_req_o), 0);
        check("t1_done_pend", 32'(fast_pending_o[2]), 0);

        // 2: equal-priority tie goes to lower index, then fast[4], then external
        set_prio(1, 3'd5);
        set_prio(4, 3'd5);
        mie_fast_i[1] = 1'b1;
        mie_fast_i[4] = 1'b1;
        mie_std_i     = 3'b100;
        expect_cause(1'b0, 5'd17);
        expect_cause(1'b0, 5'd20);
        expect_cause(1'b0, IRQ_CODE_EXT);
        irq_fast_i[1] = 1'b1; irq_fast_i[4] = 1'b1; irq_external_i = 1'b1;
        take_req("t2a");
        irq_fast_i[1] = 1'b0;
        ack();
        take_req("t2b");
        irq_fast_i[4] = 1'b0;
        ack();
        take_req("t2c");
        irq_external_i = 1'b0;
        ack();
        tick(); tick();

        // 3: edge fast[0] holds, clears on take, and a pulse in CLEAR survives
        set_prio(0, 3'd2);
        mie_fast_i[0]  = 1'b1;
        edge_mode_i[0] = 1'b1;
        irq_fast_i[0] = 1'b1;
        tick();
        irq_fast_i[0] = 1'b0;
        check("t3_pend_held", 32'(fast_pending_o[0]), 1);
        expect_cause(1'b0, 5'd16);
        take_req("t3a");
        check("t3_pend_in_req", 32'(fast_pending_o[0]), 1);
        ack();
        check("t3_clear_low", 32'(irq_req_o), 0);
        tick();
        check("t3_cleared", 32'(fast_pending_o[0]), 0);
        tick(); tick();
        check("t3_no_rereq", 32'(irq_req_o), 0);
        irq_fast_i[0] = 1'b1;
        tick();
        irq_fast_i[0] = 1'b0;
        expect_cause(1'b0, 5'd16);
        take_req("t3b");
        ack();
        irq_fast_i[0] = 1'b1;
        tick();
        irq_fast_i[0] = 1'b0;
        check("t3_set_wins", 32'(fast_pending_o[0]), 1);
        expect_cause(1'b0, 5'd16);
        take_req("t3c");
        ack();
        tick();
        check("t3_final_pend", 32'(fast_pending_o[0]), 0);

        // 4: NMI ignores mstatus; blocked by nmi_mode but still wakes
        csr_mstatus_mie_i = 1'b0;
        irq_nm_ext_i = 1'b1;
        tick();
        irq_nm_ext_i = 1'b0;
        expect_cause(1'b1, 5'd0);
        take_req("t4a");
        ack();
        tick(); tick();
        check("t4_wake_clr", 32'(wake_o), 0);
        nmi_mode_i = 1'b1;
        irq_nm_ext_i = 1'b1;
        tick();
        irq_nm_ext_i = 1'b0;
        tick(); tick();
        check("t4_blocked_req", 32'(irq_req_o), 0);
        check("t4_wake",        32'(wake_o), 1);
        check("t4_pending",     32'(irq_pending_o), 0);
        nmi_mode_i = 1'b0;
        expect_cause(1'b1, 5'd0);
        take_req("t4b");
        ack();
        tick(); tick();

        // 5: dropping mstatus in REQ withdraws a non-NMI request
        csr_mstatus_mie_i = 1'b1;
        irq_external_i    = 1'b1;
        expect_cause(1'b0, IRQ_CODE_EXT);
        take_req("t5a");
        csr_mstatus_mie_i = 1'b0;
        tick();
        check("t5_withdrawn", 32'(irq_req_o), 0);
        check("t5_still_pend", 32'(irq_pending_o), 1);
        tick(); tick();
        check("t5_stays_idle", 32'(irq_req_o), 0);
        csr_mstatus_mie_i = 1'b1;
        expect_cause(1'b0, IRQ_CODE_EXT);
        take_req("t5b");

        // 6: asynchronous reset while in REQ
        rst_n = 1'b0;
        #1;
        check("t6_req_async",   32'(irq_req_o), 0);
        check("t6_cause_async", 32'(irq_cause_o), 0);
        check("t6_pend_async",  32'(irq_pending_o), 0);
        irq_external_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("t6_fpend", 32'(fast_pending_o), 0);
        check("t6_pend",  32'(irq_pending_o), 0);
        check("t6_wake",  32'(wake_o), 0);
        check("t6_req",   32'(irq_req_o), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
